pipeline_stage_skid: RTL and testbench

PIPELINE_STAGE_SKID -- requirements
Module: pipeline_stage_skid

---
 rtl/pipeline_stage_skid_pkg.sv | 21 ++
 rtl/pipeline_stage_skid.sv | 111 +++++++++++
 tb/tb_pipeline_stage_skid.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_stage_skid_pkg.sv
// Shared types for the skid-buffered pipeline stage: occupancy states and the held entry layout.
// Entry field widths here set the default payload and register-index sizes of the stage.
package pipeline_stage_skid_pkg;

    localparam int RD_W   = 4;
    localparam int DATA_W = 64;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_e;

    typedef struct packed {
        logic              invalid;
        logic              we;
        logic [RD_W-1:0]   rd;
        logic [DATA_W-1:0] data;
    } entry_t;

endpackage

// File: rtl/pipeline_stage_skid.sv
// Two-entry skid pipeline stage, latency 1; ready_out is a flop, so upstream sees back-pressure
// one cycle late and the skid register absorbs the entry already in flight.
module pipeline_stage_skid
    import pipeline_stage_skid_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int RD_W   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              valid_in,
    output logic              ready_out,
    input  logic              invalid_in,
    input  logic              we_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              valid_out,
    input  logic              ready_in,
    output logic              invalid_out,
    output logic              we_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [DATA_W-1:0] data_out,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  stall_cnt
);

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic             rdy_q, rdy_d;
    logic [CNT_W-1:0] stall_q, stall_d;

    entry_t in_ent;
    logic   up_xfer;
    logic   dn_xfer;

    assign in_ent  = '{invalid: invalid_in, we: we_in, rd: rd_in, data: data_in};
    assign up_xfer = valid_in && rdy_q;
    assign dn_xfer = valid_out && ready_in;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    main_d  = in_ent;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (up_xfer && dn_xfer) begin
                    main_d = in_ent;
                end else if (up_xfer) begin
                    skid_d  = in_ent;
                    state_d = TWO;
                end else if (dn_xfer) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                // ready_out is low here, so only the drain side can move
                if (dn_xfer) begin
                    main_d  = skid_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) begin
            state_d = EMPTY;
        end
        rdy_d = (state_d != TWO);
    end

    always_comb begin
        stall_d = stall_q;
        if (valid_out && !ready_in && !flush && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            rdy_q   <= 1'b1;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= rdy_d;
            stall_q <= stall_d;
        end
    end

    assign ready_out   = rdy_q;
    assign valid_out   = (state_q != EMPTY);
    assign invalid_out = main_q.invalid;
    assign we_out      = main_q.we && !main_q.invalid && valid_out;
    assign rd_out      = main_q.rd;
    assign data_out    = main_q.data;
    assign occupancy   = (state_q == TWO) ? 2'd2 : (state_q == ONE) ? 2'd1 : 2'd0;
    assign stall_cnt   = stall_q;

endmodule

// File: tb/tb_pipeline_stage_skid.sv
// Directed bench for pipeline_stage_skid with an ordering scoreboard on the downstream port.
module tb_pipeline_stage_skid;

    localparam int DATA_W = 64;
    localparam int RD_W   = 4;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              valid_in;
    logic              ready_out;
    logic              invalid_in;
    logic              we_in;
    logic [RD_W-1:0]   rd_in;
    logic [DATA_W-1:0] data_in;
    logic              valid_out;
    logic              ready_in;
    logic              invalid_out;
    logic              we_out;
    logic [RD_W-1:0]   rd_out;
    logic [DATA_W-1:0] data_out;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  stall_cnt;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [RD_W-1:0]   rd;
        logic              we;
    } exp_t;

    exp_t sb[$];

    pipeline_stage_skid #(.DATA_W(DATA_W), .RD_W(RD_W), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .invalid_in (invalid_in),
        .we_in      (we_in),
        .rd_in      (rd_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .invalid_out(invalid_out),
        .we_out     (we_out),
        .rd_out     (rd_out),
        .data_out   (data_out),
        .occupancy  (occupancy),
        .stall_cnt  (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic inv, input logic we,
                         input logic [RD_W-1:0] rd, input logic [DATA_W-1:0] d);
        valid_in   = v;
        invalid_in = inv;
        we_in      = we;
        rd_in      = rd;
        data_in    = d;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ready_out"},   64'(ready_out),   64'd1);
        chk({tag, "_valid_out"},   64'(valid_out),   64'd0);
        chk({tag, "_we_out"},      64'(we_out),      64'd0);
        chk({tag, "_invalid_out"}, 64'(invalid_out), 64'd0);
        chk({tag, "_rd_out"},      64'(rd_out),      64'd0);
        chk({tag, "_data_out"},    data_out,         64'd0);
        chk({tag, "_occupancy"},   64'(occupancy),   64'd0);
        chk({tag, "_stall_cnt"},   64'(stall_cnt),   64'd0);
    endtask

    // Monitor: every downstream transfer must match the oldest accepted entry.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && !flush && valid_out && ready_in) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL out_unexpected: got data 0x%0h, expected no entry", data_out);
            end else begin
                e = sb.pop_front();
                chk("out_data", data_out, e.data);
                chk("out_rd", 64'(rd_out), 64'(e.rd));
                chk("out_we", 64'(we_out), 64'(e.we));
            end
        end
        if (!rst && !flush && valid_in && ready_out) begin
            e.data = data_in;
            e.rd   = rd_in;
            e.we   = we_in && !invalid_in;
            sb.push_back(e);
        end
        if (rst || flush) begin
            sb.delete();
        end
    end

    initial begin
        rst      = 1'b1;
        flush    = 1'b0;
        ready_in = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cyc();
        cyc();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Streaming at full rate
        ready_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, RD_W'(i), 64'h10 + 64'(i));
            cyc();
            chk("stream_data", data_out, 64'h10 + 64'(i));
            chk("stream_valid", 64'(valid_out), 64'd1);
            chk("stream_ready", 64'(ready_out), 64'd1);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        cyc();
        chk("stream_drained", 64'(valid_out), 64'd0);
        chk("stream_stall", 64'(stall_cnt), 64'd0);

        // Fill to TWO, then drain in order
        ready_in = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 4'd1, 64'hA);
        cyc();
        chk("fill_occ1", 64'(occupancy), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 4'd2, 64'hB);
        cyc();
        chk("fill_occ2", 64'(occupancy), 64'd2);
        chk("fill_ready_low", 64'(ready_out), 64'd0);
        chk("fill_main", data_out, 64'hA);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        ready_in = 1'b1;
        cyc();
        chk("drain_occ1", 64'(occupancy), 64'd1);
        chk("drain_data", data_out, 64'hB);
        chk("drain_ready", 64'(ready_out), 64'd1);
        cyc();
        chk("drain_occ0", 64'(occupancy), 64'd0);
        chk("drain_stall", 64'(stall_cnt), 64'd1);

        // Invalid entries pass as bubbles with write enable suppressed
        ready_in = 1'b0;
        drive(1'b1, 1'b1, 1'b1, 4'd5, 64'h55);
        cyc();
        chk("bubble_valid", 64'(valid_out), 64'd1);
        chk("bubble_rd", 64'(rd_out), 64'd5);
        chk("bubble_we", 64'(we_out), 64'd0);
        chk("bubble_invalid", 64'(invalid_out), 64'd1);
        drive(1'b1, 1'b0, 1'b1, 4'd5, 64'h55);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        ready_in = 1'b1;
        cyc();
        chk("live_we", 64'(we_out), 64'd1);
        chk("live_invalid", 64'(invalid_out), 64'd0);
        cyc();
        chk("live_stall", 64'(stall_cnt), 64'd2);

        // Flush in TWO with a same-cycle upstream entry
        ready_in = 1'b0;
        drive(1'b1, 1'b0, 1'b1, 4'd3, 64'h20);
        cyc();
        drive(1'b1, 1'b0, 1'b1, 4'd4, 64'h21);
        cyc();
        chk("preflush_occ", 64'(occupancy), 64'd2);
        drive(1'b1, 1'b0, 1'b1, 4'd6, 64'h22);
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk("flush_valid", 64'(valid_out), 64'd0);
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_ready", 64'(ready_out), 64'd1);
        chk("flush_stall_kept", 64'(stall_cnt), 64'd3);
        ready_in = 1'b1;
        cyc();
        chk("flush_no_ghost", 64'(valid_out), 64'd0);

        // Stall counter saturation
        ready_in = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 4'd7, 64'h30);
        cyc();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 20; i++) cyc();
        chk("stall_sat", 64'(stall_cnt), 64'd15);

        // Reset in TWO beats flush and upstream traffic
        drive(1'b1, 1'b0, 1'b1, 4'd8, 64'h31);
        cyc();
        chk("prerst_occ", 64'(occupancy), 64'd2);
        drive(1'b1, 1'b0, 1'b1, 4'd9, 64'h32);
        flush = 1'b1;
        rst   = 1'b1;
        cyc();
        rst   = 1'b0;
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        chk_reset_outputs("midrst");

        ready_in = 1'b1;
        cyc();
        cyc();
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
